// File: rtl/wb_cmd_master.sv
// Wishbone classic single-beat initiator fed by a valid/ready command channel.
// Results (read data or timeout error) are returned on a valid/ready response channel.
module wb_cmd_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i
);

    localparam int unsigned SEL_W  = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TMO_LAST_I = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_ack;
    logic               w_timeout;
    logic               w_rsp_done;

    logic               r_stb;
    logic               r_we;
    logic [ADDR_W-1:0]  r_adr;
    logic [DATA_W-1:0]  r_dat;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_dat;
    logic               r_rsp_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack is tested before the timeout so a same-edge ack completes cleanly.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_rsp_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm_ack_i) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_stb <= 1'b1;
                r_we  <= cmd_we;
                r_adr <= cmd_adr;
                r_dat <= cmd_dat;
                r_sel <= cmd_sel;
                r_cnt <= '0;
            end
            if ((r_state == S_BUS) && !w_ack && !w_timeout && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ack) begin
                r_stb       <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            end
            if (w_timeout) begin
                r_stb       <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_dat   <= '0;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign wbm_cyc_o = r_stb;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: programmable-latency slave, randomized commands,
// expected results from a transaction-level model of ack/timeout outcome.
module tb_wb_cmd_master;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    // Slave: acks on stb cycle number ack_dly (1-based), 0 = never acks.
    int            ack_dly;
    int            stb_seen;
    logic          stray_ack;
    logic [DW-1:0] slave_rdata;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stb_seen <= 0;
        else        stb_seen <= wbm_stb_o ? stb_seen + 1 : 0;
    end

    assign wbm_ack_i = stray_ack | (wbm_stb_o && (ack_dly != 0) && (stb_seen == ack_dly - 1));
    assign wbm_dat_i = slave_rdata;

    wb_cmd_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat),
        .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat),
        .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i)
    );

    // Transaction-level outcome: ack within the window wins, otherwise timeout.
    int            e_len;
    bit            e_err;
    logic [DW-1:0] e_dat;

    function automatic void model(input bit we, input int dly, input logic [DW-1:0] rd);
        if (dly != 0 && dly <= int'(TMO)) begin
            e_len = dly;
            e_err = 1'b0;
            e_dat = we ? '0 : rd;
        end else begin
            e_len = int'(TMO);
            e_err = 1'b1;
            e_dat = '0;
        end
    endfunction

    // Observations from the last transaction.
    int            o_len;
    bit            o_rdy0, o_cyc1, o_bus_ok, o_rdy_low, o_rsp_first, o_stable, o_no_acc, o_done;
    logic          o_err;
    logic [DW-1:0] o_dat;

    task automatic run_cmd(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input int dly, input int bp, input bit stray);
        int guard;
        ack_dly = dly;
        @(negedge clk);
        o_rdy0    = (cmd_ready === 1'b1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
        o_cyc1 = (wbm_cyc_o === 1'b1);
        o_len = 0; o_bus_ok = 1'b1; o_rdy_low = 1'b1; guard = 0;
        while (wbm_stb_o === 1'b1 && guard < 200) begin
            o_len++;
            if (!(wbm_cyc_o === 1'b1 && wbm_we_o === we && wbm_adr_o === adr &&
                  wbm_dat_o === dat && wbm_sel_o === sel)) o_bus_ok = 1'b0;
            if (cmd_ready !== 1'b0) o_rdy_low = 1'b0;
            @(negedge clk);
            guard++;
        end
        o_rsp_first = (rsp_valid === 1'b1);
        o_dat = rsp_dat; o_err = rsp_err;
        if (cmd_ready !== 1'b0) o_rdy_low = 1'b0;
        o_stable = 1'b1; o_no_acc = 1'b1;
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1; cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom;
            cmd_sel = SW'($urandom);
            stray_ack = stray;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== o_dat || rsp_err !== o_err) o_stable = 1'b0;
            if (cmd_ready !== 1'b0) o_rdy_low = 1'b0;
            if (wbm_cyc_o !== 1'b0) o_no_acc = 1'b0;
        end
        stray_ack = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o_done = (rsp_valid === 1'b0 && cmd_ready === 1'b1 && wbm_cyc_o === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) $display("FAIL rst_cyc_stb: got %b%b expected 00", wbm_cyc_o, wbm_stb_o); else pass_cnt++;
        chk_cnt++; if ({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) $display("FAIL rst_bus: got adr %h dat %h expected 0", wbm_adr_o, wbm_dat_o); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== '0) $display("FAIL rst_rsp: got v%b e%b d%h expected 0", rsp_valid, rsp_err, rsp_dat); else pass_cnt++;
        chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_wait();
        slave_rdata = 32'hA5A5_1111;
        model(1'b1, 3, slave_rdata);
        run_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 3, 0, 1'b0);
        chk_cnt++; if (!o_rdy0 || !o_cyc1) $display("FAIL wr_issue: got ready %b cyc_next %b expected 1 1", o_rdy0, o_cyc1); else pass_cnt++;
        chk_cnt++; if (o_len != e_len) $display("FAIL wr_stb_len: got %0d expected %0d", o_len, e_len); else pass_cnt++;
        chk_cnt++; if (!o_bus_ok) $display("FAIL wr_bus_values: got mismatch expected we=1 adr 30000004 dat deadbeef sel f"); else pass_cnt++;
        chk_cnt++; if (!o_rsp_first || o_err !== e_err || o_dat !== e_dat) $display("FAIL wr_rsp: got v%b e%b d%h expected v1 e%b d%h", o_rsp_first, o_err, o_dat, e_err, e_dat); else pass_cnt++;
        chk_cnt++; if (!o_done) $display("FAIL wr_done: got busy after handshake expected idle"); else pass_cnt++;
    endtask

    task automatic test_read_zero_wait();
        slave_rdata = 32'h1234_5678;
        model(1'b0, 1, slave_rdata);
        run_cmd(1'b0, 32'h3000_0010, $urandom, SW'($urandom), 1, 0, 1'b0);
        chk_cnt++; if (o_len != e_len) $display("FAIL rd_stb_len: got %0d expected %0d", o_len, e_len); else pass_cnt++;
        chk_cnt++; if (!o_rsp_first || o_dat !== e_dat || o_err !== e_err) $display("FAIL rd_rsp: got v%b d%h e%b expected v1 d%h e%b", o_rsp_first, o_dat, o_err, e_dat, e_err); else pass_cnt++;
        chk_cnt++; if (!o_rdy_low) $display("FAIL rd_cmd_ready: got 1 during transfer expected 0"); else pass_cnt++;
    endtask

    task automatic test_timeout();
        slave_rdata = 32'hCAFE_0001;
        model(1'b0, 0, slave_rdata);
        run_cmd(1'b0, 32'h3000_0020, '0, 4'hF, 0, 0, 1'b0);
        chk_cnt++; if (o_len != e_len) $display("FAIL tmo_stb_len: got %0d expected %0d", o_len, e_len); else pass_cnt++;
        chk_cnt++; if (o_err !== e_err || o_dat !== e_dat) $display("FAIL tmo_rsp: got e%b d%h expected e%b d%h", o_err, o_dat, e_err, e_dat); else pass_cnt++;
        model(1'b0, 2, slave_rdata);
        run_cmd(1'b0, 32'h3000_0024, '0, 4'hF, 2, 0, 1'b0);
        chk_cnt++; if (o_len != e_len || o_err !== e_err || o_dat !== e_dat) $display("FAIL tmo_next: got len %0d e%b d%h expected len %0d e%b d%h", o_len, o_err, o_dat, e_len, e_err, e_dat); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        slave_rdata = 32'h0BAD_F00D;
        model(1'b0, 2, slave_rdata);
        run_cmd(1'b0, 32'h3000_0030, '0, 4'h3, 2, 5, 1'b0);
        chk_cnt++; if (!o_stable) $display("FAIL bp_stable: got response change expected held for 5 cycles"); else pass_cnt++;
        chk_cnt++; if (!o_no_acc || !o_rdy_low) $display("FAIL bp_no_accept: got no_acc %b rdy_low %b expected 1 1", o_no_acc, o_rdy_low); else pass_cnt++;
        chk_cnt++; if (o_dat !== e_dat || o_err !== e_err) $display("FAIL bp_rsp: got d%h e%b expected d%h e%b", o_dat, o_err, e_dat, e_err); else pass_cnt++;
        model(1'b1, 1, slave_rdata);
        run_cmd(1'b1, 32'h3000_0034, 32'h5555_AAAA, 4'hC, 1, 0, 1'b0);
        chk_cnt++; if (!o_rdy0 || !o_bus_ok || o_len != e_len || o_dat !== e_dat) $display("FAIL bp_next: got rdy %b bus %b len %0d d%h expected 1 1 %0d %h", o_rdy0, o_bus_ok, o_len, o_dat, e_len, e_dat); else pass_cnt++;
    endtask

    task automatic test_collision_stray();
        logic [AW-1:0] adr_before;
        slave_rdata = 32'h7777_0016;
        model(1'b0, 16, slave_rdata);
        run_cmd(1'b0, 32'h3000_0040, '0, 4'hF, 16, 0, 1'b0);
        chk_cnt++; if (o_len != e_len || o_err !== e_err || o_dat !== e_dat) $display("FAIL coll_ack16: got len %0d e%b d%h expected len %0d e%b d%h", o_len, o_err, o_dat, e_len, e_err, e_dat); else pass_cnt++;
        model(1'b0, 17, slave_rdata);
        run_cmd(1'b0, 32'h3000_0044, '0, 4'hF, 17, 0, 1'b0);
        chk_cnt++; if (o_len != e_len || o_err !== e_err || o_dat !== e_dat) $display("FAIL coll_ack17: got len %0d e%b d%h expected len %0d e%b d%h", o_len, o_err, o_dat, e_len, e_err, e_dat); else pass_cnt++;
        adr_before = wbm_adr_o;
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        chk_cnt++; if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_adr_o !== adr_before) $display("FAIL stray_idle: got cyc %b rv %b rdy %b adr %h expected 0 0 1 %h", wbm_cyc_o, rsp_valid, cmd_ready, wbm_adr_o, adr_before); else pass_cnt++;
        model(1'b0, 4, slave_rdata);
        run_cmd(1'b0, 32'h3000_0048, '0, 4'hF, 4, 3, 1'b1);
        chk_cnt++; if (!o_stable || !o_no_acc || o_dat !== e_dat || o_err !== e_err) $display("FAIL stray_resp: got stable %b no_acc %b d%h e%b expected 1 1 %h %b", o_stable, o_no_acc, o_dat, o_err, e_dat, e_err); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        ack_dly = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0050; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (wbm_cyc_o !== 1'b1) $display("FAIL arst_in_bus: got cyc %b expected 1", wbm_cyc_o); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL arst_immediate: got cyc %b stb %b rv %b rdy %b expected 0 0 0 1", wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) $display("FAIL arst_no_rsp: got rv %b cyc %b expected 0 0", rsp_valid, wbm_cyc_o); else pass_cnt++;
        slave_rdata = 32'h600D_DA7A;
        model(1'b0, 2, slave_rdata);
        run_cmd(1'b0, 32'h3000_0054, '0, 4'hF, 2, 0, 1'b0);
        chk_cnt++; if (o_len != e_len || o_dat !== e_dat || o_err !== e_err) $display("FAIL arst_read: got len %0d d%h e%b expected %0d %h %b", o_len, o_dat, o_err, e_len, e_dat, e_err); else pass_cnt++;
    endtask

    task automatic test_random();
        bit            we;
        int            dly;
        int            bp;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        for (int n = 0; n < 25; n++) begin
            we = 1'($urandom); dly = int'($urandom_range(0, 20)); bp = int'($urandom_range(0, 3));
            adr = $urandom; dat = $urandom; sel = SW'($urandom);
            slave_rdata = $urandom | 32'h1;
            model(we, dly, slave_rdata);
            run_cmd(we, adr, dat, sel, dly, bp, 1'($urandom));
            chk_cnt++;
            if (o_len != e_len || !o_bus_ok || !o_rsp_first || o_dat !== e_dat || o_err !== e_err ||
                !o_stable || !o_no_acc || !o_rdy_low || !o_done)
                $display("FAIL rand_%0d: got len %0d bus %b rv %b d%h e%b stable %b done %b expected len %0d bus 1 rv 1 d%h e%b stable 1 done 1",
                         n, o_len, o_bus_ok, o_rsp_first, o_dat, o_err, o_stable, o_done, e_len, e_dat, e_err);
            else pass_cnt++;
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; stray_ack = 1'b0; ack_dly = 0; slave_rdata = '0;
        test_reset();
        test_write_wait();
        test_read_zero_wait();
        test_timeout();
        test_backpressure();
        test_collision_stray();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
